// File: rtl/param_lock_controller.sv
// Keypad lock controller with several password slots, a shared digit entry
// buffer, an error counter and a timed lockout with a flashing LED.
module param_lock_controller #(
  parameter int NUM_DIGITS     = 6,
  parameter int NUM_SLOTS      = 4,
  parameter int MAX_ERRORS     = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int FLASH_HALF     = 50,
  parameter int SW             = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    mode,
  input  logic [3:0]              digit_in,
  input  logic                    digit_valid,
  input  logic [SW-1:0]           slot_sel,
  input  logic                    enter,
  output logic [4*NUM_DIGITS-1:0] disp,
  output logic                    unlocked,
  output logic                    error_flag,
  output logic                    locked_out,
  output logic                    led,
  output logic [3:0]              err_count
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int TW = $clog2(LOCKOUT_CYCLES);
  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  typedef enum logic [1:0] {IDLE, OPEN, LOCKOUT} state_t;

  state_t         state_q;
  logic [BW-1:0]  buf_q;
  logic [BW-1:0]  slot_q [NUM_SLOTS];
  logic [CW-1:0]  cnt_q;
  logic           invalid_q;
  logic           auth_q;
  logic           mode_q;
  logic           err_pulse_q;
  logic           led_q;
  logic [3:0]     err_q;
  logic [TW-1:0]  lock_tmr_q;
  logic [FW-1:0]  flash_tmr_q;

  logic [3:0]           digit_d;
  logic [BW-1:0]        buf_d;
  logic [CW-1:0]        cnt_d;
  logic [3:0]           err_d;
  logic [NUM_SLOTS-1:0] slot_hit;
  logic                 full;
  logic                 hit;
  logic                 mode_rise;
  logic                 prog_locked;

  // Non-BCD keys are stored as E so they can never equal a programmed slot.
  assign digit_d   = (digit_in > 4'd9) ? 4'hE : digit_in;
  assign buf_d     = {buf_q[BW-5:0], digit_d};
  assign full      = (cnt_q == CW'(NUM_DIGITS));
  assign cnt_d     = full ? cnt_q : cnt_q + CW'(1);
  assign err_d     = err_q + 4'd1;
  assign mode_rise = mode && !mode_q;

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot_cmp
      assign slot_hit[gi] = (buf_q == slot_q[gi]);
    end
  endgenerate

  assign hit = full && !invalid_q && (|slot_hit);

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      cnt_q       <= '0;
      invalid_q   <= 1'b0;
      auth_q      <= 1'b0;
      mode_q      <= 1'b0;
      err_pulse_q <= 1'b0;
      led_q       <= 1'b0;
      err_q       <= '0;
      lock_tmr_q  <= '0;
      flash_tmr_q <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) slot_q[s] <= '0;
    end else begin
      mode_q      <= mode;
      err_pulse_q <= 1'b0;
      if (mode_rise) auth_q <= 1'b0;
      case (state_q)
        LOCKOUT: begin
          if (lock_tmr_q == '0) begin
            state_q <= IDLE;
            err_q   <= '0;
            led_q   <= 1'b0;
            auth_q  <= 1'b0;
          end else begin
            lock_tmr_q <= lock_tmr_q - TW'(1);
            if (flash_tmr_q == '0) begin
              led_q       <= ~led_q;
              flash_tmr_q <= FW'(FLASH_HALF - 1);
            end else begin
              flash_tmr_q <= flash_tmr_q - FW'(1);
            end
          end
        end
        default: begin
          if (mode) begin
            // Any activity in unlock mode closes an open lock; the activity itself still counts.
            if (mode_rise || digit_valid || enter) state_q <= IDLE;
            if (enter) begin
              buf_q     <= '0;
              cnt_q     <= '0;
              invalid_q <= 1'b0;
              if (hit) begin
                state_q <= OPEN;
                err_q   <= '0;
                auth_q  <= 1'b1;
              end else begin
                err_q <= err_d;
                if (err_d == 4'(MAX_ERRORS)) begin
                  state_q     <= LOCKOUT;
                  lock_tmr_q  <= TW'(LOCKOUT_CYCLES - 1);
                  flash_tmr_q <= FW'(FLASH_HALF - 1);
                  led_q       <= 1'b1;
                end
              end
            end else if (digit_valid) begin
              buf_q <= buf_d;
              cnt_q <= cnt_d;
              if (digit_in > 4'd9) invalid_q <= 1'b1;
            end
          end else if (auth_q) begin
            if (enter) begin
              buf_q     <= '0;
              cnt_q     <= '0;
              invalid_q <= 1'b0;
              if (full && !invalid_q) begin
                for (int s = 0; s < NUM_SLOTS; s++)
                  if (int'(slot_sel) == s) slot_q[s] <= buf_q;
              end else begin
                err_pulse_q <= 1'b1;
              end
            end else if (digit_valid) begin
              buf_q <= buf_d;
              cnt_q <= cnt_d;
              if (digit_in > 4'd9) invalid_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign prog_locked = !mode && !auth_q;
  assign disp        = prog_locked ? {NUM_DIGITS{4'hE}} : buf_q;
  assign error_flag  = prog_locked || err_pulse_q;
  assign unlocked    = (state_q == OPEN);
  assign locked_out  = (state_q == LOCKOUT);
  assign led         = led_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_param_lock_controller.sv
// Directed bench for param_lock_controller: a queue-based model checked every
// cycle, plus hand-computed expectations along the test plan.
module tb_param_lock_controller;
  localparam int ND = 6;
  localparam int NS = 4;
  localparam int ME = 3;
  localparam int LC = 20;
  localparam int FH = 5;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            clr = 1'b1;
  logic            mode = 1'b1;
  logic [3:0]      digit_in = 4'd0;
  logic            digit_valid = 1'b0;
  logic [SW-1:0]   slot_sel = '0;
  logic            enter = 1'b0;
  logic [4*ND-1:0] disp;
  logic            unlocked, error_flag, locked_out, led;
  logic [3:0]      err_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  param_lock_controller #(
    .NUM_DIGITS(ND), .NUM_SLOTS(NS), .MAX_ERRORS(ME),
    .LOCKOUT_CYCLES(LC), .FLASH_HALF(FH)
  ) dut (
    .clk(clk), .clr(clr), .mode(mode), .digit_in(digit_in),
    .digit_valid(digit_valid), .slot_sel(slot_sel), .enter(enter),
    .disp(disp), .unlocked(unlocked), .error_flag(error_flag),
    .locked_out(locked_out), .led(led), .err_count(err_count)
  );

  // Model state: entry digits oldest-first, slots as digit lists.
  logic [3:0] m_entry[$];
  bit         m_inv, m_open, m_auth, m_locked, m_pulse, m_prev;
  logic [3:0] m_slot [NS][ND];
  int         m_errs, m_elapsed;

  function automatic bit m_match();
    bit any = 1'b0;
    if (m_entry.size() != ND || m_inv) return 1'b0;
    for (int s = 0; s < NS; s++) begin
      bit same = 1'b1;
      for (int d = 0; d < ND; d++) if (m_slot[s][d] != m_entry[d]) same = 1'b0;
      if (same) any = 1'b1;
    end
    return any;
  endfunction

  function automatic logic [4*ND-1:0] m_disp();
    logic [4*ND-1:0] r = '0;
    if (!mode && !m_auth) r = {ND{4'hE}};
    else for (int i = 0; i < m_entry.size(); i++) r[4*i +: 4] = m_entry[m_entry.size()-1-i];
    return r;
  endfunction

  task automatic m_push(input logic [3:0] d);
    m_entry.push_back((d > 4'd9) ? 4'hE : d);
    if (m_entry.size() > ND) void'(m_entry.pop_front());
    if (d > 4'd9) m_inv = 1'b1;
  endtask

  always @(posedge clk) begin : model_upd
    bit rise;
    if (clr) begin
      m_entry.delete();
      m_inv = 0; m_open = 0; m_auth = 0; m_locked = 0; m_pulse = 0; m_prev = 0;
      m_errs = 0; m_elapsed = 0;
      foreach (m_slot[s, d]) m_slot[s][d] = 4'd0;
    end else begin
      rise = mode && !m_prev;
      m_prev = mode;
      m_pulse = 0;
      if (rise) m_auth = 0;
      if (m_locked) begin
        m_elapsed++;
        if (m_elapsed == LC) begin m_locked = 0; m_errs = 0; m_auth = 0; end
      end else if (mode) begin
        if (rise || enter || digit_valid) m_open = 0;
        if (enter) begin
          if (m_match()) begin m_open = 1; m_errs = 0; m_auth = 1; end
          else begin
            m_errs++;
            if (m_errs == ME) begin m_locked = 1; m_elapsed = 0; end
          end
          m_entry.delete(); m_inv = 0;
        end else if (digit_valid) m_push(digit_in);
      end else if (m_auth) begin
        if (enter) begin
          if (m_entry.size() == ND && !m_inv) begin
            if (int'(slot_sel) < NS) for (int d = 0; d < ND; d++) m_slot[slot_sel][d] = m_entry[d];
          end else m_pulse = 1;
          m_entry.delete(); m_inv = 0;
        end else if (digit_valid) m_push(digit_in);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("disp", 32'(disp), 32'(m_disp()));
      check("unlocked", 32'(unlocked), 32'(m_open));
      check("locked_out", 32'(locked_out), 32'(m_locked));
      check("led", 32'(led), 32'(m_locked && ((m_elapsed / FH) % 2 == 0)));
      check("err_count", 32'(err_count), 32'(m_errs[3:0]));
      check("error_flag", 32'(error_flag), 32'((!mode && !m_auth) || m_pulse));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    digit_in = d; digit_valid = 1'b1;
    step();
    digit_valid = 1'b0;
  endtask

  task automatic press();
    enter = 1'b1;
    step();
    enter = 1'b0;
  endtask

  task automatic send_code(input logic [23:0] c);
    logic [23:0] v = c;
    for (int i = ND - 1; i >= 0; i--) key(v[4*i +: 4]);
    press();
    $display("[TB] mode=%0d code=%06h -> unlocked=%0b err_count=%0d error_flag=%0b locked_out=%0b",
             mode, c, unlocked, err_count, error_flag, locked_out);
  endtask

  task automatic set_mode(input logic m);
    mode = m;
    step();
  endtask

  initial begin
    step(); step();
    chk_en = 1'b1;
    check("rst_unlocked", 32'(unlocked), 32'd0);
    check("rst_locked", 32'(locked_out), 32'd0);
    check("rst_disp", 32'(disp), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    clr = 1'b0;
    step();

    // Default slots are all zero.
    send_code(24'h000000);
    check("t1_unlocked", 32'(unlocked), 32'd1);
    check("t1_err", 32'(err_count), 32'd0);

    // Program slot 2, then use it.
    slot_sel = 2'd2;
    set_mode(1'b0);
    check("t2_open_in_prog", 32'(unlocked), 32'd1);
    check("t2_no_err", 32'(error_flag), 32'd0);
    send_code(24'h123456);
    key(4'd7);
    press();
    check("t2_short_pulse", 32'(error_flag), 32'd1);
    step();
    check("t2_pulse_end", 32'(error_flag), 32'd0);
    set_mode(1'b1);
    check("t2_mode_rise_idle", 32'(unlocked), 32'd0);
    send_code(24'h123456);
    check("t2_slot2_open", 32'(unlocked), 32'd1);
    for (int i = 1; i <= 6; i++) key(4'(i));
    digit_in = 4'd9; digit_valid = 1'b1; enter = 1'b1;
    step();
    digit_valid = 1'b0; enter = 1'b0;
    check("t2_enter_wins_open", 32'(unlocked), 32'd1);
    check("t2_enter_wins_disp", 32'(disp), 32'd0);
    send_code(24'h123457);
    check("t2_wrong_unlocked", 32'(unlocked), 32'd0);
    check("t2_wrong_err", 32'(err_count), 32'd1);

    // Short entry, invalid digit, overflow of the buffer.
    for (int i = 1; i <= 5; i++) key(4'(i));
    check("t5_short_disp", 32'(disp), 32'h012345);
    press();
    check("t5_short_err", 32'(err_count), 32'd2);
    send_code(24'h123456);
    check("t5_clear_err", 32'(err_count), 32'd0);
    for (int i = 1; i <= 5; i++) key(4'(i));
    key(4'hB);
    check("t5_invalid_disp", 32'(disp), 32'h12345E);
    press();
    check("t5_invalid_miss", 32'(unlocked), 32'd0);
    check("t5_invalid_err", 32'(err_count), 32'd1);
    for (int i = 0; i <= 6; i++) key(4'(i));
    check("t5_seven_disp", 32'(disp), 32'h123456);
    press();
    check("t5_seven_open", 32'(unlocked), 32'd1);

    // Program mode without authorisation.
    clr = 1'b1; step(); clr = 1'b0;
    set_mode(1'b0);
    check("t3_err_flag", 32'(error_flag), 32'd1);
    check("t3_disp_e", 32'(disp), 32'hEEEEEE);
    send_code(24'h987654);
    check("t3_disp_still_e", 32'(disp), 32'hEEEEEE);
    set_mode(1'b1);
    send_code(24'h987654);
    check("t3_write_ignored", 32'(unlocked), 32'd0);
    send_code(24'h000000);
    check("t3_zero_open", 32'(unlocked), 32'd1);

    // Lockout after three misses.
    for (int i = 0; i < 3; i++) send_code(24'h111111);
    check("t4_locked", 32'(locked_out), 32'd1);
    check("t4_led_start", 32'(led), 32'd1);
    check("t4_err_max", 32'(err_count), 32'd3);
    for (int i = 0; i < 4; i++) step();
    check("t4_led_hold", 32'(led), 32'd1);
    step();
    check("t4_led_toggle", 32'(led), 32'd0);
    send_code(24'h000000);
    check("t4_input_ignored", 32'(unlocked), 32'd0);
    for (int i = 0; i < 7; i++) step();
    check("t4_last_locked", 32'(locked_out), 32'd1);
    step();
    check("t4_expired", 32'(locked_out), 32'd0);
    check("t4_err_clear", 32'(err_count), 32'd0);
    check("t4_led_off", 32'(led), 32'd0);
    send_code(24'h000000);
    check("t4_open_after", 32'(unlocked), 32'd1);

    // clr in the middle of a lockout.
    slot_sel = 2'd1;
    set_mode(1'b0);
    send_code(24'h135791);
    set_mode(1'b1);
    send_code(24'h135791);
    check("t6_slot1_open", 32'(unlocked), 32'd1);
    for (int i = 0; i < 3; i++) send_code(24'h222222);
    step(); step(); step();
    check("t6_mid_lock", 32'(locked_out), 32'd1);
    clr = 1'b1;
    step();
    check("t6_clr_locked", 32'(locked_out), 32'd0);
    check("t6_clr_led", 32'(led), 32'd0);
    check("t6_clr_err", 32'(err_count), 32'd0);
    check("t6_clr_unlocked", 32'(unlocked), 32'd0);
    check("t6_clr_flag", 32'(error_flag), 32'd0);
    clr = 1'b0;
    send_code(24'h135791);
    check("t6_slot_cleared", 32'(unlocked), 32'd0);
    send_code(24'h000000);
    check("t6_zero_open", 32'(unlocked), 32'd1);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
